// File: rtl/shared_op_arbiter.sv
// shared_op_arbiter: one add/sub/mul unit shared round-robin among clients,
// with per-client operand and result slots on req/ack pull handshakes.
module shared_op_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int data_width = 32,
  parameter string op = "add",
  parameter int LATENCY = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic [NUM_CLIENTS-1:0]                in_req,
  input  logic [NUM_CLIENTS-1:0]                in_ack,
  input  logic [NUM_CLIENTS*2*data_width-1:0]   in_data,
  input  logic [NUM_CLIENTS-1:0]                out_req,
  output logic [NUM_CLIENTS-1:0]                out_ack,
  output logic [NUM_CLIENTS*data_width-1:0]     out_data,
  output logic                                  busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]        grant_idx,
  output logic [31:0]                           op_count
);
  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int CW = $clog2(LATENCY) + 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2*data_width-1:0] opnd [NUM_CLIENTS];
  logic [data_width-1:0] res [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] opv, resv, elig;
  logic [IW-1:0] ptr, g;
  logic found;
  logic [CW-1:0] cnt;
  logic [data_width-1:0] a, b, f;
  assign elig = opv & ~resv;
  assign f = op == "sub" ? a - b : op == "mul" ? a * b : a + b;
  // first eligible client after the last one served
  always_comb begin
    g = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      if (!found && elig[IW'((int'(ptr) + k) % NUM_CLIENTS)]) begin
        g = IW'((int'(ptr) + k) % NUM_CLIENTS);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_req <= '0;
      out_ack <= '0;
      out_data <= '0;
      busy <= 1'b0;
      grant_idx <= '0;
      op_count <= '0;
      opv <= '0;
      resv <= '0;
      ptr <= IW'(NUM_CLIENTS - 1);
      state <= IDLE;
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        in_req[i] <= ~opv[i] & ~in_ack[i];
        out_ack[i] <= 1'b0;
        if (in_ack[i] && !opv[i]) opv[i] <= 1'b1;
        if (resv[i] && out_req[i] && !out_ack[i]) begin
          out_ack[i] <= 1'b1;
          out_data[i*data_width +: data_width] <= res[i];
          resv[i] <= 1'b0;
        end
      end
      if (state == IDLE) begin
        if (found) begin
          opv[g] <= 1'b0;
          grant_idx <= g;
          cnt <= CW'(LATENCY - 1);
          busy <= 1'b1;
          state <= BUSY;
        end
      end else if (cnt == '0) begin
        resv[grant_idx] <= 1'b1;
        ptr <= grant_idx;
        op_count <= op_count + 32'd1;
        busy <= 1'b0;
        state <= IDLE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  // datapath slots carry no reset; their valid flags gate every use
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (in_ack[i] && !opv[i]) opnd[i] <= in_data[2*data_width*i +: 2*data_width];
    if (state == IDLE && found) {b, a} <= opnd[g];
    if (state == BUSY && cnt == '0) res[grant_idx] <= f;
  end
endmodule

// File: tb/tb_shared_op_arbiter.sv
// tb_shared_op_arbiter: directed and random checks of shared_op_arbiter against
// a per-client scoreboard of expected results plus grant-order/timing rules.
module tb_shared_op_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] in_req, in_ack = '0, out_req = '0, out_ack;
  logic [255:0] in_data = '0;
  logic [127:0] out_data;
  logic busy;
  logic [1:0] grant_idx;
  logic [31:0] op_count;
  logic [1:0] s_in_req, s_in_ack = '0, s_out_req = '0, s_out_ack;
  logic [127:0] s_in_data = '0;
  logic [63:0] s_out_data;
  logic s_busy, s_gi;
  logic [31:0] s_cnt;
  logic [1:0] m_in_req, m_in_ack = '0, m_out_req = '0, m_out_ack;
  logic [127:0] m_in_data = '0;
  logic [63:0] m_out_data;
  logic m_busy, m_gi;
  logic [31:0] m_cnt;
  int passed = 0, total = 0, cyc = 0, nacks = 0, bcount = 0;
  logic [31:0] q [4][$];
  int dlv [4];
  int last_ack_cyc [4];
  int glog [$];
  int gcyc [$];
  logic [3:0] prev_ack = '0;
  logic prev_busy = 1'b0;

  shared_op_arbiter #(.NUM_CLIENTS(4), .data_width(32), .op("add"), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data), .busy(busy),
    .grant_idx(grant_idx), .op_count(op_count));
  shared_op_arbiter #(.NUM_CLIENTS(2), .data_width(32), .op("sub"), .LATENCY(1)) dut_sub (
    .clk(clk), .rst(rst), .in_req(s_in_req), .in_ack(s_in_ack), .in_data(s_in_data),
    .out_req(s_out_req), .out_ack(s_out_ack), .out_data(s_out_data), .busy(s_busy),
    .grant_idx(s_gi), .op_count(s_cnt));
  shared_op_arbiter #(.NUM_CLIENTS(2), .data_width(32), .op("mul"), .LATENCY(1)) dut_mul (
    .clk(clk), .rst(rst), .in_req(m_in_req), .in_ack(m_in_ack), .in_data(m_in_data),
    .out_req(m_out_req), .out_ack(m_out_ack), .out_data(m_out_data), .busy(m_busy),
    .grant_idx(m_gi), .op_count(m_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance to the next falling edge and score deliveries and grants seen there
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (out_ack[i]) begin
        chk($sformatf("ack_spacing%0d", i), 64'(prev_ack[i]), 64'd0);
        chk($sformatf("ack_expected%0d", i), 64'(q[i].size() > 0), 64'd1);
        if (q[i].size() > 0) chk($sformatf("out_data%0d", i), 64'(out_data[i*32 +: 32]), 64'(q[i].pop_front()));
        dlv[i]++;
        last_ack_cyc[i] = cyc;
      end
    end
    prev_ack = out_ack;
    if (busy && !prev_busy) begin
      glog.push_back(int'(grant_idx));
      gcyc.push_back(cyc);
    end
    if (busy) bcount++;
    prev_busy = busy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_ack = '0;
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      dlv[i] = 0;
    end
    step();
    rst = 1'b0;
    prev_busy = 1'b0;
    prev_ack = '0;
    glog.delete();
    gcyc.delete();
    nacks = 0;
    bcount = 0;
    step();
    step();
  endtask

  task automatic ack1(input int i, input logic [31:0] a, input logic [31:0] b);
    chk($sformatf("in_req_before_ack%0d", i), 64'(in_req[i]), 64'd1);
    in_data[i*64 +: 64] = {b, a};
    in_ack[i] = 1'b1;
    q[i].push_back(a + b);
    nacks++;
    step();
    in_ack = '0;
  endtask

  task automatic run(input int n, input logic [3:0] mask, input bit rnd);
    logic [31:0] a, b;
    repeat (n) begin
      for (int i = 0; i < 4; i++) begin
        if (in_req[i] && mask[i] && (!rnd || $urandom_range(1) == 1)) begin
          a = $urandom;
          b = $urandom;
          in_data[i*64 +: 64] = {b, a};
          in_ack[i] = 1'b1;
          q[i].push_back(a + b);
          nacks++;
        end
      end
      step();
      in_ack = '0;
      if (rnd) out_req = 4'($urandom);
    end
  endtask

  function automatic int grants_to(input int c);
    int n = 0;
    foreach (glog[k]) if (glog[k] == c) n++;
    return n;
  endfunction

  initial begin
    step();
    chk("rst_in_req", 64'(in_req), 64'd0);
    chk("rst_out_ack", 64'(out_ack), 64'd0);
    chk("rst_out_data", 64'(out_data != 0), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    do_reset();
    chk("in_req_after_release", 64'(in_req), 64'hF);
    // wrap behaviour of sub and mul variants
    s_in_data = {32'd3, 32'd10, 32'd1, 32'd0};
    m_in_data = {32'd2, 32'hFFFF_FFFF, 32'h1_0000, 32'h1_0000};
    s_in_ack = 2'b11;
    m_in_ack = 2'b11;
    s_out_req = 2'b11;
    m_out_req = 2'b11;
    step();
    s_in_ack = '0;
    m_in_ack = '0;
    repeat (8) step();
    chk("sub_wrap", 64'(s_out_data[31:0]), 64'hFFFF_FFFF);
    chk("sub_plain", 64'(s_out_data[63:32]), 64'd7);
    chk("mul_wrap", 64'(m_out_data[31:0]), 64'd0);
    chk("mul_trunc", 64'(m_out_data[63:32]), 64'hFFFF_FFFE);
    // single client add
    do_reset();
    out_req = 4'b0010;
    ack1(1, 32'd5, 32'd7);
    run(8, 4'h0, 1'b0);
    chk("t1_grants", 64'(glog.size()), 64'd1);
    if (glog.size() > 0) begin
      chk("t1_grant_idx", 64'(glog[0]), 64'd1);
      chk("t1_grant_to_ack", 64'(last_ack_cyc[1] - gcyc[0]), 64'd4);
    end
    chk("t1_busy_cycles", 64'(bcount), 64'd3);
    chk("t1_dlv1", 64'(dlv[1]), 64'd1);
    chk("t1_dlv_other", 64'(dlv[0] + dlv[2] + dlv[3]), 64'd0);
    chk("t1_op_count", 64'(op_count), 64'd1);
    chk("t1_out_data", 64'(out_data[63:32]), 64'd12);
    // asynchronous reset while busy with cnt==1
    out_req = 4'h0;
    ack1(3, 32'd1, 32'd2);
    step();
    step();
    chk("mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_in_req", 64'(in_req), 64'd0);
    chk("mid_out_ack", 64'(out_ack), 64'd0);
    chk("mid_out_data", 64'(out_data != 0), 64'd0);
    chk("mid_busy_clr", 64'(busy), 64'd0);
    chk("mid_grant_idx", 64'(grant_idx), 64'd0);
    chk("mid_op_count", 64'(op_count), 64'd0);
    do_reset();
    out_req = 4'hF;
    chk("mid_in_req_back", 64'(in_req), 64'hF);
    run(10, 4'h0, 1'b0);
    chk("mid_no_ack", 64'(dlv[0] + dlv[1] + dlv[2] + dlv[3]), 64'd0);
    chk("mid_no_grant", 64'(glog.size()), 64'd0);
    // round robin from reset: all four present in one cycle
    for (int i = 0; i < 4; i++) begin
      in_data[i*64 +: 64] = {32'd10, 32'(i)};
      q[i].push_back(32'(i) + 32'd10);
    end
    in_ack = 4'hF;
    step();
    in_ack = '0;
    run(20, 4'h0, 1'b0);
    chk("rr_grants", 64'(glog.size()), 64'd4);
    for (int k = 0; k < 4 && k < glog.size(); k++) begin
      chk($sformatf("rr_order%0d", k), 64'(glog[k]), 64'(k));
      if (k > 0) chk($sformatf("rr_space%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd4);
      chk($sformatf("rr_result%0d", k), 64'(out_data[k*32 +: 32]), 64'(k + 10));
    end
    chk("rr_op_count", 64'(op_count), 64'd4);
    // backpressure on client 2
    do_reset();
    out_req = 4'b1011;
    run(60, 4'hF, 1'b0);
    chk("bp_one_grant2", 64'(grants_to(2)), 64'd1);
    chk("bp_others_cycle", 64'(grants_to(0) > 2 && grants_to(1) > 2 && grants_to(3) > 2), 64'd1);
    chk("bp_pending2", 64'(q[2].size()), 64'd2);
    glog.delete();
    out_req = 4'hF;
    run(30, 4'b1011, 1'b0);
    chk("bp_regrant2", 64'(grants_to(2)), 64'd1);
    chk("bp_drained2", 64'(q[2].size()), 64'd0);
    // back-to-back results for one client
    do_reset();
    out_req = 4'b0001;
    run(40, 4'b0001, 1'b0);
    run(10, 4'h0, 1'b0);
    chk("sp_drained", 64'(q[0].size()), 64'd0);
    chk("sp_delivered", 64'(dlv[0]), 64'(nacks));
    // random traffic
    do_reset();
    run(500, 4'hF, 1'b1);
    out_req = 4'hF;
    run(100, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("rnd_drained%0d", i), 64'(q[i].size()), 64'd0);
    chk("rnd_op_count", 64'(op_count), 64'(nacks));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
